topk_stream: RTL
================

# topk_stream

Streaming top-K selector, the parametrised successor to the fixed 16-wide feedback top-16 unit. It accepts frames of arbitrary length as beats of `2**LOG_LANES` elements over a valid/ready handshake. It keeps a sorted K-entry table with per-entry source indices and supports max or min selection per frame. At frame end it presents the K best values, their indices and a fill count on a valid/ready output port, then clears itself for the next frame.

## Interface
- `DATA_WIDTH`, 32, element width
- `LOG_LANES`, 2, log2 of elements per input beat (L = 2**LOG_LANES)
- `K`, 16, table depth (number of results), K >= 1
- `IDX_WIDTH`, 16, element index width
- `SIGNED`, 1, 1: compare as two's complement; 0: unsigned
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  input beat valid
- `i_ready`  out  1  block can accept a beat
- `i_last`  in  1  beat is final beat of frame
- `i_min`  in  1  0: keep largest, 1: keep smallest; sampled on first beat of frame
- `x`  in  DATA_WIDTH*L  beat data, lane j at bits [j*DATA_WIDTH +: DATA_WIDTH]
- `o_valid`  out  1  result valid
- `o_ready`  in  1  downstream accepts result
- `y`  out  DATA_WIDTH*K  sorted results, slot 0 = best
- `y_idx`  out  IDX_WIDTH*K  frame index of each slot
- `o_count`  out  $clog2(K+1)  number of filled slots, min(K, elements in frame)

## Operation
- Table: K entries of {value, index, filled}. Kept sorted, best first. Filled entries are always contiguous from slot 0.
- FSM states:
  - IDLE: `i_ready`=1. Handshake (`i_valid`&`i_ready`) latches `x`, `i_last` and, if this is the first beat of the frame, `i_min`. Goes to INS with lane pointer 0.
  - INS: `i_ready`=0. One lane is inserted per cycle, lane 0 first. After lane L-1 is inserted, goes to OUT if the latched last flag is set, otherwise to IDLE.
  - OUT: `o_valid`=1, `i_ready`=0. Outputs are held stable until `o_ready`. On the handshake the table is cleared, the index counter resets to 0, the first-beat flag is set, and the FSM goes to IDLE.
- Insertion of element e with index n:
  - "better" means strictly greater (max mode) or strictly less (min mode), using signed or unsigned compare per `SIGNED`.
  - Position p = number of filled entries that are not worse than e, i.e. entries better than or equal to e.
  - Entries p..K-2 shift down one slot, the old slot K-1 is dropped, and e is written to slot p.
  - If p = K, e is discarded.
  - Ties: the earlier element ranks higher.
- Index counter: increments once per inserted lane and wraps modulo 2**IDX_WIDTH. Lane j of beat b in a frame has index b*L+j (mod).
- `o_count` increments on each insertion while below K and saturates at K.
- Unfilled slots output value 0 and index 0.
- `y`/`y_idx`/`o_count` reflect the live table at all times but are only meaningful while `o_valid`=1.
- A single-beat frame (`i_last` on the first beat) is legal.
- The `i_min` value on non-first beats is ignored.

## Timing
- Reset (`rst`=0, asynchronous): FSM to IDLE, table cleared, `i_ready`=1, `o_valid`=0, `y`=0, `y_idx`=0, `o_count`=0, index counter 0, first-beat flag set. Reset mid-frame or during OUT discards everything.
- Beat accepted at edge E: lane j is written at edge E+1+j, and the FSM is back in IDLE (`i_ready`=1) after edge E+L. Throughput is one beat per L+1 cycles.
- Last beat accepted at edge E: `o_valid` rises after edge E+L.
- OUT handshake at edge F: `o_valid`=0 and `i_ready`=1 after F. The next beat can be accepted at F+1.
- `i_valid` low in IDLE: the block holds, with no state change.
- `o_ready` low: OUT holds indefinitely and no input is accepted (back-pressure).
- `o_ready` high with `o_valid` low has no effect.

## Test plan
- K=4, L=4, SIGNED=1, max mode. One beat {lane0..3} = {5,-3,9,5}, `i_last`=1 -> y = {9,5,5,-3}, y_idx = {2,0,3,1}, o_count = 4, `o_valid` 4 cycles after accept.
- K=4, L=4, max mode, two beats {1,2,3,4} then {8,0,6,7} (last) -> y = {8,7,6,4}, y_idx = {4,7,6,3}.
- Same two beats, min mode on first beat (with `i_min` toggled to 0 on second beat) -> y = {0,1,2,3}, y_idx = {5,0,1,2}.
- K=16, L=4, one beat {7,7,7,7} last -> o_count = 4, slots 0-3 = 7 with idx 0-3, slots 4-15 = 0, idx 0.
- Hold `o_ready`=0 for 10 cycles with `i_valid`=1 -> `i_ready` stays 0, outputs stable. Raise `o_ready` -> one-cycle handshake, then `i_ready`=1 and the table is cleared (next frame's indices start at 0).
- SIGNED=0 vs SIGNED=1 with {0xFFFFFFFF,1,0,2} last, max mode -> unsigned slot 0 = 0xFFFFFFFF, signed slot 0 = 2. Assert `rst`=0 during INS -> immediate `o_valid`=0, `i_ready`=1, `o_count`=0.

Source files
------------

// File: rtl/topk_stream.sv
// topk_stream: streaming top-K selector.
//   Accepts frames as beats of L = 2**LOG_LANES elements over a valid/ready
//   handshake. Inserts one lane per cycle into a sorted K-entry table (best
//   first), then presents the table on a valid/ready result port at frame end
//   and clears itself for the next frame.
// Ports:
//   clk, rst (async, active-low)
//   i_valid/i_ready/i_last/i_min/x   input beat handshake, frame end, mode, data
//   o_valid/o_ready                  result handshake
//   y, y_idx, o_count                sorted values, source indices, fill count
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an input beat, i_ready=1
// S_INS  | inserting the latched beat, one lane per cycle
// S_OUT  | frame result held on outputs until o_ready
module topk_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_LANES  = 2,
    parameter int K          = 16,
    parameter int IDX_WIDTH  = 16,
    parameter int SIGNED     = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_valid,
    output logic                                 i_ready,
    input  logic                                 i_last,
    input  logic                                 i_min,
    input  logic [DATA_WIDTH*(2**LOG_LANES)-1:0] x,
    output logic                                 o_valid,
    input  logic                                 o_ready,
    output logic [DATA_WIDTH*K-1:0]              y,
    output logic [IDX_WIDTH*K-1:0]               y_idx,
    output logic [$clog2(K+1)-1:0]               o_count
);

    localparam int L  = 2**LOG_LANES;
    localparam int CW = $clog2(K+1);
    localparam int LW = (LOG_LANES > 0) ? LOG_LANES : 1;

    typedef enum logic [1:0] {S_IDLE, S_INS, S_OUT} state_t;

    state_t                     state_q, state_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic [DATA_WIDTH*L-1:0]    beat_q, beat_d;
    logic                       last_q, last_d;
    logic                       min_q, min_d;
    logic                       first_q, first_d;
    logic [IDX_WIDTH-1:0]       idx_q, idx_d;
    logic [CW-1:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]      val_q [K];
    logic [DATA_WIDTH-1:0]      val_d [K];
    logic [IDX_WIDTH-1:0]       vid_q [K];
    logic [IDX_WIDTH-1:0]       vid_d [K];

    logic [DATA_WIDTH-1:0]      elem;
    logic [K-1:0]               keep;
    logic [K:0]                 keep_ext;

    function automatic logic elem_better(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b,
                                         input logic mn);
        logic gt;
        logic lt;
        gt = 1'b0;
        lt = 1'b0;
        if (SIGNED != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return mn ? lt : gt;
    endfunction

    assign elem = beat_q[lane_q*DATA_WIDTH +: DATA_WIDTH];

    // keep[i]: slot i is filled and at least as good as the new element.
    // Because the table is sorted, keep is a prefix; its length is the
    // insertion position. Equal entries stay ahead, so earlier wins ties.
    always_comb begin
        keep = '0;
        for (int i = 0; i < K; i++) begin
            keep[i] = (CW'(i) < count_q) && !elem_better(elem, val_q[i], min_q);
        end
        // keep_ext[i] is keep[i-1], with a virtual always-kept slot above 0
        keep_ext = {keep, 1'b1};
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        last_d  = last_q;
        min_d   = min_q;
        first_d = first_q;
        idx_d   = idx_q;
        count_d = count_q;
        val_d   = val_q;
        vid_d   = vid_q;
        i_ready = 1'b0;
        o_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    beat_d = x;
                    last_d = i_last;
                    if (first_q) begin
                        min_d   = i_min;
                        first_d = 1'b0;
                    end
                    lane_d  = '0;
                    state_d = S_INS;
                end
            end
            S_INS: begin
                // Slot 0 takes the element unless it is kept; other slots
                // take the element at the insertion point or shift down.
                if (!keep[0]) begin
                    val_d[0] = elem;
                    vid_d[0] = idx_q;
                end
                for (int i = 1; i < K; i++) begin
                    if (!keep[i]) begin
                        if (keep_ext[i]) begin
                            val_d[i] = elem;
                            vid_d[i] = idx_q;
                        end else begin
                            val_d[i] = val_q[i-1];
                            vid_d[i] = vid_q[i-1];
                        end
                    end
                end
                idx_d = idx_q + 1'b1;
                if (count_q < CW'(K)) begin
                    count_d = count_q + 1'b1;
                end
                lane_d = lane_q + 1'b1;
                if (lane_q == LW'(L-1)) begin
                    state_d = last_q ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    for (int i = 0; i < K; i++) begin
                        val_d[i] = '0;
                        vid_d[i] = '0;
                    end
                    count_d = '0;
                    idx_d   = '0;
                    first_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            beat_q  <= '0;
            last_q  <= 1'b0;
            min_q   <= 1'b0;
            first_q <= 1'b1;
            idx_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < K; i++) begin
                val_q[i] <= '0;
                vid_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            beat_q  <= beat_d;
            last_q  <= last_d;
            min_q   <= min_d;
            first_q <= first_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            for (int i = 0; i < K; i++) begin
                val_q[i] <= val_d[i];
                vid_q[i] <= vid_d[i];
            end
        end
    end

    always_comb begin
        y     = '0;
        y_idx = '0;
        for (int i = 0; i < K; i++) begin
            y[i*DATA_WIDTH +: DATA_WIDTH]    = val_q[i];
            y_idx[i*IDX_WIDTH +: IDX_WIDTH]  = vid_q[i];
        end
    end

    assign o_count = count_q;

endmodule
